fft512_frame_ctrl: RTL and testbench

Frame sequencer and output monitor for the 512-point streaming FFT core. It accepts a continuous I/Q sample stream and cuts it into FFT blocks, driving the core's sink handshake and its sop/eop framing. It latches the transform direction per block. On the core's source side it passes results downstream, checks output framing, captures the block exponent and counts frames. It sits between the ADC/decimator stage and the fft512 instance.

---
 rtl/fft512_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_fft512_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft512_frame_ctrl.sv
// Frame sequencer and output monitor for the 512-point streaming FFT core.
// Sink side is a zero-latency ready/valid passthrough gated by block framing; source side is monitored in place.
module fft512_frame_ctrl #(
  parameter int FRAME_LEN = 512,
  parameter int DW        = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          inv_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          sink_valid,
  output logic          sink_sop,
  output logic          sink_eop,
  input  logic          sink_ready,
  output logic [1:0]    sink_error,
  output logic [DW-1:0] sink_real,
  output logic [DW-1:0] sink_imag,
  output logic          inverse,
  input  logic          source_valid,
  input  logic          source_sop,
  input  logic          source_eop,
  input  logic [1:0]    source_error,
  input  logic [DW-1:0] source_real,
  input  logic [DW-1:0] source_imag,
  input  logic [5:0]    source_exp,
  output logic          source_ready,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  input  logic          out_ready,
  output logic          frame_done,
  output logic [5:0]    blk_exp,
  output logic          frm_err,
  input  logic          clr_err,
  output logic [15:0]   frames_in,
  output logic [15:0]   frames_out
);

  localparam int            CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] in_cnt_q, out_cnt_q, out_cnt_d;
  logic          inverse_q, frame_done_q, frm_err_q, frm_err_d;
  logic [5:0]    blk_exp_q;
  logic [15:0]   frames_in_q, frames_out_q;
  logic          run, in_acc, in_last, out_acc, out_last, sop_bad, out_bad;

  assign run        = (state_q == RUN);
  assign sink_valid = run & in_valid;
  assign in_ready   = run & sink_ready;
  assign in_acc     = sink_valid & sink_ready;
  assign in_last    = (in_cnt_q == LAST);
  assign sink_sop   = (in_cnt_q == '0);
  assign sink_eop   = in_last;
  assign sink_error = 2'b00;
  assign sink_real  = in_real;
  assign sink_imag  = in_imag;
  assign inverse    = inverse_q;
  assign frames_in  = frames_in_q;

  // Direction is only ever reloaded when a block starts, so it is stable sop..eop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      inverse_q   <= 1'b0;
      frames_in_q <= 16'd0;
    end else if (!run) begin
      if (enable) begin
        state_q   <= RUN;
        inverse_q <= inv_req;
        in_cnt_q  <= '0;
      end
    end else if (in_acc) begin
      if (in_last) begin
        in_cnt_q    <= '0;
        frames_in_q <= frames_in_q + 16'd1;
        if (enable) inverse_q <= inv_req;
        else        state_q   <= IDLE;
      end else begin
        in_cnt_q <= in_cnt_q + CW'(1);
      end
    end
  end

  assign source_ready = out_ready;
  assign out_valid    = source_valid;
  assign out_sop      = source_sop;
  assign out_eop      = source_eop;
  assign out_real     = source_real;
  assign out_imag     = source_imag;
  assign frame_done   = frame_done_q;
  assign blk_exp      = blk_exp_q;
  assign frm_err      = frm_err_q;
  assign frames_out   = frames_out_q;

  assign out_acc  = source_valid & out_ready;
  assign out_last = (out_cnt_q == LAST);
  assign sop_bad  = source_sop & (out_cnt_q != '0);
  assign out_bad  = sop_bad | (source_eop & !out_last) | (source_error != 2'b00);

  // A stray sop is trusted as the real block start, so counting resumes from it.
  always_comb begin
    out_cnt_d = out_cnt_q;
    frm_err_d = frm_err_q;
    if (out_acc) begin
      if (sop_bad)       out_cnt_d = CW'(1);
      else if (out_last) out_cnt_d = '0;
      else               out_cnt_d = out_cnt_q + CW'(1);
    end
    if (out_acc && out_bad) frm_err_d = 1'b1;
    else if (clr_err)       frm_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q    <= '0;
      frm_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      blk_exp_q    <= 6'd0;
      frames_out_q <= 16'd0;
    end else begin
      out_cnt_q    <= out_cnt_d;
      frm_err_q    <= frm_err_d;
      frame_done_q <= out_acc & out_last;
      if (out_acc && out_last) begin
        blk_exp_q    <= source_exp;
        frames_out_q <= frames_out_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft512_frame_ctrl.sv
// Bench for fft512_frame_ctrl: handshake table, then randomized streams against a block-level model.
module tb_fft512_frame_ctrl;

  localparam int FRAME_LEN = 512;
  localparam int DW        = 12;

  logic          clk, reset_n, enable, inv_req;
  logic          in_valid, in_ready, sink_valid, sink_sop, sink_eop, sink_ready, inverse;
  logic [DW-1:0] in_real, in_imag, sink_real, sink_imag;
  logic [1:0]    sink_error, source_error;
  logic          source_valid, source_sop, source_eop, source_ready;
  logic [DW-1:0] source_real, source_imag, out_real, out_imag;
  logic [5:0]    source_exp, blk_exp;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic          frame_done, frm_err, clr_err;
  logic [15:0]   frames_in, frames_out;

  fft512_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .inv_req(inv_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .sink_error(sink_error), .sink_real(sink_real), .sink_imag(sink_imag), .inverse(inverse),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
    .source_exp(source_exp), .source_ready(source_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_real(out_real),
    .out_imag(out_imag), .out_ready(out_ready), .frame_done(frame_done), .blk_exp(blk_exp),
    .frm_err(frm_err), .clr_err(clr_err), .frames_in(frames_in), .frames_out(frames_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_errors;

  // Reference model: total accepted input beats since reset, and output block position.
  int         m_total, o_pos, o_frames;
  bit         m_run, m_inv, e_done, e_ferr, fixed_exp, entered;
  logic [5:0] e_blk;

  typedef struct {
    bit run, iv, sr, orr, sv, ssop;
    bit e_ir, e_svld, e_srdy, e_ovld, e_osop;
  } vec_t;
  vec_t vecs[8];

  int sops[$], eops[$];
  int done_cnt, start_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_total = 0; o_pos = 0; o_frames = 0;
    m_run = 0; m_inv = 0; e_done = 0; e_ferr = 0; e_blk = 6'd0;
  endtask

  task automatic drive_in(input bit en, input bit iv, input bit sr, input bit inv);
    enable = en; in_valid = iv; sink_ready = sr; inv_req = inv;
    in_real = 12'($urandom); in_imag = 12'($urandom);
  endtask

  task automatic drive_src(input bit v, input bit r, input bit force_sop,
                           input logic [1:0] err, input bit clr);
    source_valid = v; out_ready = r;
    source_sop = (o_pos == 0) || force_sop;
    source_eop = (o_pos == FRAME_LEN - 1);
    source_error = err; clr_err = clr;
    source_real = 12'($urandom); source_imag = 12'($urandom);
    source_exp = fixed_exp ? 6'd5 : 6'($urandom);
  endtask

  task automatic check_all();
    int pos;
    pos = m_total % FRAME_LEN;
    chk("in_ready", in_ready, m_run & sink_ready);
    chk("sink_valid", sink_valid, m_run & in_valid);
    chk("sink_sop", sink_sop, pos == 0);
    chk("sink_eop", sink_eop, pos == FRAME_LEN - 1);
    chk("sink_data", {sink_error, sink_real, sink_imag}, {2'b00, in_real, in_imag});
    chk("inverse", inverse, m_inv);
    chk("frames_in", frames_in, (m_total / FRAME_LEN) % 65536);
    chk("src_passthru", {source_ready, out_valid, out_sop, out_eop, out_real, out_imag},
        {out_ready, source_valid, source_sop, source_eop, source_real, source_imag});
    chk("frame_done", frame_done, e_done);
    chk("blk_exp", blk_exp, e_blk);
    chk("frm_err", frm_err, e_ferr);
    chk("frames_out", frames_out, o_frames % 65536);
  endtask

  // Check current outputs, cross one clock edge, advance the model by that edge.
  task automatic step();
    bit i_acc, o_acc, bad;
    #1;
    check_all();
    i_acc = m_run && in_valid && sink_ready;
    o_acc = source_valid && out_ready;
    bad   = o_acc && ((source_sop && o_pos != 0) || (source_eop && o_pos != FRAME_LEN - 1)
                      || source_error != 2'b00);
    @(posedge clk);
    if (!m_run) begin
      if (enable) begin m_run = 1; m_inv = inv_req; end
    end else if (i_acc) begin
      m_total++;
      if (m_total % FRAME_LEN == 0) begin
        if (enable) m_inv = inv_req;
        else        m_run = 0;
      end
    end
    e_done = 0;
    if (o_acc) begin
      if (o_pos == FRAME_LEN - 1) begin e_done = 1; e_blk = source_exp; o_frames++; end
      if (source_sop && o_pos != 0) o_pos = 1;
      else                          o_pos = (o_pos + 1) % FRAME_LEN;
    end
    if (bad)          e_ferr = 1;
    else if (clr_err) e_ferr = 0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; fixed_exp = 1; entered = 0;
    model_reset();
    //        run iv sr orr sv ssop | ir svld srdy ovld osop
    vecs[0] = '{0, 1, 1, 0, 1, 1,  0, 0, 0, 1, 1};
    vecs[1] = '{0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0};
    vecs[4] = '{1, 1, 0, 1, 0, 0,  0, 1, 1, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 1, 1,  1, 0, 0, 1, 1};
    vecs[6] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[7] = '{1, 1, 0, 0, 1, 0,  0, 1, 0, 1, 0};

    // Reset state, with live inputs on both sides.
    reset_n = 0;
    drive_in(1, 1, 1, 1);
    drive_src(1, 1, 1, 2'b11, 0);
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_counters", {frames_in, frames_out}, 32'd0);
    chk("rst_flags", {inverse, frame_done, frm_err, blk_exp}, 9'd0);
    chk("rst_passthru", {out_valid, source_ready, out_sop}, 3'b111);
    @(posedge clk); #1;
    reset_n = 1;
    drive_in(0, 0, 0, 0);
    drive_src(0, 0, 0, 2'b00, 0);
    @(posedge clk); #1;

    // Handshake table, no beat ever accepted.
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].run && !entered) begin
        enable = 1; in_valid = 0; sink_ready = 0; out_ready = 0; source_valid = 0;
        @(posedge clk); #1;
        entered = 1;
      end
      enable = vecs[k].run; in_valid = vecs[k].iv; sink_ready = vecs[k].sr;
      out_ready = vecs[k].orr; source_valid = vecs[k].sv; source_sop = vecs[k].ssop;
      source_eop = 0; source_error = 2'b00;
      #1;
      chk("vec_in_ready", in_ready, vecs[k].e_ir);
      chk("vec_sink_valid", sink_valid, vecs[k].e_svld);
      chk("vec_source_ready", source_ready, vecs[k].e_srdy);
      chk("vec_out", {out_valid, out_sop}, {vecs[k].e_ovld, vecs[k].e_osop});
      chk("vec_sink_sop", sink_sop, 1);
      @(posedge clk); #1;
    end
    reset_n = 0; #1; reset_n = 1;
    model_reset();
    drive_in(0, 0, 0, 0);
    drive_src(0, 0, 0, 2'b00, 0);

    // Steady stream: 1024 beats.
    drive_in(1, 1, 1, 0);
    step();
    for (int i = 0; i < 1024; i++) begin
      drive_in(1, 1, 1, 0);
      drive_src(0, 0, 0, 2'b00, 0);
      #1;
      if (sink_sop) sops.push_back(i);
      if (sink_eop) eops.push_back(i);
      step();
    end
    chk("steady_sop_count", sops.size(), 2);
    chk("steady_eop_count", eops.size(), 2);
    if (sops.size() == 2) chk("steady_sop_idx", {sops[0][15:0], sops[1][15:0]}, {16'd0, 16'd512});
    if (eops.size() == 2) chk("steady_eop_idx", {eops[0][15:0], eops[1][15:0]}, {16'd511, 16'd1023});
    chk("steady_frames_in", frames_in, 2);

    // Random throttling on the sink side with random direction requests.
    for (int i = 0; i < 1200; i++) begin
      drive_in(1, 1'($urandom), 1'($urandom), 1'($urandom));
      drive_src(0, 0, 0, 2'b00, 0);
      step();
    end

    // One clean output block, throttled.
    done_cnt = 0;
    for (int i = 0; i < 6000 && o_frames < 1; i++) begin
      drive_in(1, 1'($urandom), 1'($urandom), 1'($urandom));
      drive_src($urandom_range(0, 3) != 0, 1'($urandom), 0, 2'b00, 0);
      step();
      if (frame_done) done_cnt++;
    end
    drive_src(0, 0, 0, 2'b00, 0);
    step();
    if (frame_done) done_cnt++;
    chk("blk_done_pulses", done_cnt, 1);
    chk("blk_frames_out", frames_out, 1);
    chk("blk_exp_5", blk_exp, 5);
    chk("blk_frm_err", frm_err, 0);

    // Framing errors, resync and clear priority.
    fixed_exp = 0;
    drive_in(0, 0, 0, 0);
    for (int i = 0; i < 2000 && o_pos != 37; i++) begin
      drive_in(1, 1'($urandom), 1'($urandom), 0);
      drive_src(1'($urandom), 1'($urandom), 0, 2'b00, 0);
      step();
    end
    drive_src(1, 1, 1, 2'b00, 0); step();
    chk("err_sop_set", frm_err, 1);
    for (int i = 0; i < 5; i++) begin drive_src(1, 1, 0, 2'b00, 0); step(); end
    chk("err_sticky", frm_err, 1);
    drive_src(0, 0, 0, 2'b00, 1); step();
    chk("err_clr", frm_err, 0);
    drive_src(1, 1, 0, 2'b01, 0); step();
    chk("err_source_error", frm_err, 1);
    drive_src(0, 0, 0, 2'b00, 1); step();
    chk("err_clr2", frm_err, 0);
    drive_src(1, 1, 0, 2'b10, 1); step();
    chk("err_set_wins", frm_err, 1);
    drive_src(0, 0, 0, 2'b00, 1); step();
    chk("err_clr3", frm_err, 0);
    for (int i = 0; i < 4000 && o_frames < 2; i++) begin
      drive_in(1, 1'($urandom), 1'($urandom), 0);
      drive_src(1'($urandom), 1'($urandom), 0, 2'b00, 0);
      step();
    end
    chk("resync_frame_done", frame_done, 1);
    chk("resync_frm_err", frm_err, 0);
    chk("resync_frames_out", frames_out, 2);
    drive_src(0, 0, 0, 2'b00, 0);

    // Drop enable mid-block, then re-enable with an inverse request.
    start_total = m_total;
    for (int i = 0; i < 3000 && !(m_total % FRAME_LEN == 0 && m_total != start_total); i++) begin
      drive_in(1, 1, 1, 0); step();
    end
    for (int i = 0; i < 200 && m_total % FRAME_LEN != 100; i++) begin
      drive_in(1, 1, 1, 0); step();
    end
    chk("drop_inverse_before", inverse, 0);
    for (int i = 0; i < 3000 && m_run; i++) begin
      drive_in(0, 1'($urandom), 1'($urandom), 1); step();
    end
    drive_in(0, 1, 1, 1);
    #1;
    chk("drop_idle_in_ready", in_ready, 0);
    chk("drop_block_complete", m_total % FRAME_LEN, 0);
    step();
    drive_in(1, 0, 0, 1); step();
    drive_in(1, 1, 1, 0);
    #1;
    chk("reen_sop", sink_sop, 1);
    chk("reen_inverse", inverse, 1);
    step();
    for (int i = 0; i < 400 && m_total % FRAME_LEN != 300; i++) begin
      drive_in(1, 1, 1, 0); step();
    end

    // Asynchronous reset mid-block.
    drive_in(1, 1, 1, 1);
    drive_src(1, 1, 0, 2'b00, 0);
    #2;
    reset_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_sink", {sink_valid, sink_sop, sink_eop}, 3'b010);
    chk("arst_counters", {frames_in, frames_out}, 32'd0);
    chk("arst_flags", {inverse, frame_done, frm_err, blk_exp}, 9'd0);
    chk("arst_passthru", {out_valid, source_ready}, 2'b11);
    model_reset();
    @(posedge clk); #1;
    drive_in(0, 0, 0, 0);
    drive_src(0, 0, 0, 2'b00, 0);
    @(posedge clk); #1;
    reset_n = 1;
    drive_in(1, 1, 1, 0); step();
    drive_in(1, 1, 1, 0);
    #1;
    chk("post_rst_sop", {in_ready, sink_sop}, 2'b11);
    step();
    for (int i = 0; i < 600; i++) begin
      drive_in(1, 1'($urandom), 1'($urandom), 1'($urandom)); step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
